pspin_ctrl_regfile: RTL and testbench
=====================================

Name: pspin_ctrl_regfile

Overview:
- Second-generation PsPIN control/status register file on the NIC AXI-Lite control bus.
- Terminates AXI-Lite directly, with no external register-interface shim.
- Provides cluster fetch-enable and aux reset, sticky end-of-compute flags, and live busy/MPQ-full status.
- Exposes NUM_STDOUT independent pop-on-read stdout FIFO channels.
- All inputs are already synchronous to clk; CDC is done outside this block.

Parameters:
- ADDR_WIDTH, 16, AXI-Lite address width; only bits [12:2] are decoded.
- DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- NUM_CLUSTERS, 2, cluster count, 1..32.
- NUM_MPQ, 256, MPQ count, 1..1024; NUM_MPQ_WORDS = ceil(NUM_MPQ/32).
- NUM_STDOUT, 2, stdout FIFO channels, 1..64.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_axil_aw*/w*/b*/ar*/r*  AXI-Lite slave: awaddr[ADDR_WIDTH], awprot[3], awvalid, awready, wdata[32], wstrb[4], wvalid, wready, bresp[2], bvalid, bready, araddr, arprot, arvalid, arready, rdata[32], rresp[2], rvalid, rready
- cl_fetch_en_o  out  NUM_CLUSTERS  per-cluster fetch enable
- aux_rst_o  out  1  PsPIN aux reset, active-high
- cl_eoc_i  in  NUM_CLUSTERS  cluster end-of-compute level
- cl_busy_i  in  NUM_CLUSTERS  cluster busy level
- mpq_full_i  in  NUM_MPQ  MPQ full flags
- stdout_rd_en  out  NUM_STDOUT  one-cycle pop strobe per channel
- stdout_dout  in  32*NUM_STDOUT  FWFT FIFO head data; channel c is bits [32c+:32]
- stdout_data_valid  in  NUM_STDOUT  FIFO head valid per channel

Behaviour:
- Address map (byte offsets; unused high bits ignored):
  - 0x0000 FETCH_EN, RW, bits [NUM_CLUSTERS-1:0]
  - 0x0004 AUX_RST, RW, bit 0
  - 0x0008 EOC_STICKY, W1C
  - 0x0100 EOC, RO
  - 0x0104 BUSY, RO
  - 0x0108+4k MPQ_FULL word k, RO, for k < NUM_MPQ_WORDS; bit j = mpq_full_i[32k+j], bits beyond NUM_MPQ read 0
  - 0x1000+4c STDOUT_POP channel c, RO with side effect
  - 0x1800 STDOUT_VALID, RO; bit c = stdout_data_valid[c], channels 0..31 only
- Unimplemented register bits read 0 and ignore writes.
- Reset values: FETCH_EN=0, AUX_RST=1, EOC_STICKY=0, eoc_prev=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, stdout_rd_en=0.
- Outputs: cl_fetch_en_o and aux_rst_o are driven directly from their registers.
- Write channel:
  - awready and wready are asserted together for one cycle when awvalid && wvalid && !bvalid && !awready. A lone AW or W is never accepted.
  - The register updates on the handshake cycle, per byte lane where wstrb is set.
  - bvalid rises the next cycle and holds until bready. One write is outstanding at most.
  - bresp = OKAY for mapped writable addresses; SLVERR (2'b10) for RO or unmapped addresses, with no state change.
- EOC_STICKY:
  - Bit i sets on each rising edge of cl_eoc_i[i] (cl_eoc_i & ~eoc_prev).
  - A write of 1 clears bit i; a write of 0 leaves it.
  - If a set and a clear land on the same cycle, set wins.
- Read channel:
  - arready is asserted for one cycle when arvalid && !rvalid && !arready.
  - rdata/rresp are registered from the handshake cycle; rvalid rises the next cycle (latency 1) and holds, with data stable, until rready.
  - One read is outstanding at most.
  - Unmapped address: rdata=0xFFFFFFFF, rresp=SLVERR.
- STDOUT_POP channel c:
  - If stdout_data_valid[c] is high at the AR handshake: rdata = stdout_dout[c]; stdout_rd_en[c] pulses high for exactly that handshake cycle.
  - Otherwise: rdata = 0xFFFFFFFF and no pulse. rresp = OKAY in both cases.
  - c >= NUM_STDOUT is unmapped.
  - A stalled rready never causes a second pop.
- Simultaneous events:
  - Read and write handshakes in the same cycle are both serviced.
  - A read of a register written that cycle returns the pre-write value.
- Reset mid-transaction: all pending responses are dropped, bvalid=rvalid=0 next cycle, and registers return to reset values.

Test Plan:
- Reset, then read 0x0004 → rdata=0x1, OKAY. Read 0x0000 → 0x0. Confirm aux_rst_o=1 and cl_fetch_en_o=0.
- Write 0x0000 data=0xFFFFFFFF, wstrb=0x1, NUM_CLUSTERS=2 → bresp=OKAY, cl_fetch_en_o=2'b11. Read back → 0x00000003.
- Pulse cl_eoc_i[1] for 1 cycle → EOC_STICKY reads 0x2, EOC reads 0x0. Write 0x2 to 0x0008 on the same cycle as a new eoc[1] rising edge → bit stays 1. A later write of 0x2 → reads 0x0.
- mpq_full_i[40]=1, NUM_MPQ=256 → read 0x010C returns 0x00000100. Read 0x0128 → 0xFFFFFFFF, SLVERR.
- Channel 1 valid, dout=0xDEADBEEF, rready held low 5 cycles → exactly one stdout_rd_en[1] pulse at the AR handshake, rdata=0xDEADBEEF stable until rready. With channel 1 empty → 0xFFFFFFFF, no pulse.
- AW valid without W for 10 cycles → awready stays 0; W arrives → single accept. Assert rst with bvalid pending → bvalid=0 next cycle.

Source files
------------

// File: rtl/pspin_ctrl_regfile.sv
// PsPIN control/status register file terminating AXI-Lite directly.
// Provides cluster control, sticky end-of-compute flags, live status and pop-on-read stdout FIFOs.
module pspin_ctrl_regfile #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_CLUSTERS = 2,
    parameter int NUM_MPQ      = 256,
    parameter int NUM_STDOUT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [DATA_WIDTH-1:0]    s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]    s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic [2:0]               s_axil_arprot,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [DATA_WIDTH-1:0]    s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,

    output logic [NUM_CLUSTERS-1:0]  cl_fetch_en_o,
    output logic                     aux_rst_o,
    input  logic [NUM_CLUSTERS-1:0]  cl_eoc_i,
    input  logic [NUM_CLUSTERS-1:0]  cl_busy_i,
    input  logic [NUM_MPQ-1:0]       mpq_full_i,
    output logic [NUM_STDOUT-1:0]    stdout_rd_en,
    input  logic [32*NUM_STDOUT-1:0] stdout_dout,
    input  logic [NUM_STDOUT-1:0]    stdout_data_valid
);

    localparam int NUM_MPQ_WORDS  = (NUM_MPQ + 31) / 32;
    localparam int NUM_VALID_BITS = (NUM_STDOUT > 32) ? 32 : NUM_STDOUT;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                    r_awready, r_arready, r_bvalid, r_rvalid;
    logic [1:0]              r_bresp, r_rresp;
    logic [31:0]             r_rdata;
    logic [NUM_CLUSTERS-1:0] r_fetch_en, r_eoc_sticky, r_eoc_prev;
    logic                    r_aux_rst;

    logic [10:0]             w_wr_idx, w_rd_idx;
    logic                    w_wr_hs, w_rd_hs, w_wr_ok;
    logic [31:0]             w_wmask;
    logic [NUM_CLUSTERS-1:0] w_fetch_next, w_eoc_clr, w_eoc_rise;
    logic [NUM_MPQ_WORDS*32-1:0] w_mpq_pad;
    logic [31:0]             w_valid32, w_rd_data;
    logic [1:0]              w_rd_resp;
    logic [NUM_STDOUT-1:0]   w_pop;
    logic                    w_unused;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr, w_wmask};

    assign w_wr_idx = s_axil_awaddr[12:2];
    assign w_rd_idx = s_axil_araddr[12:2];
    assign w_wr_hs  = r_awready && s_axil_awvalid && s_axil_wvalid;
    assign w_rd_hs  = r_arready && s_axil_arvalid;
    assign w_wr_ok  = (w_wr_idx == 11'h000) || (w_wr_idx == 11'h001) || (w_wr_idx == 11'h002);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_wmask[8*b +: 8] = {8{s_axil_wstrb[b]}};
        end
    end

    assign w_fetch_next = (r_fetch_en & ~w_wmask[NUM_CLUSTERS-1:0])
                        | (s_axil_wdata[NUM_CLUSTERS-1:0] & w_wmask[NUM_CLUSTERS-1:0]);
    assign w_eoc_clr    = (w_wr_hs && w_wr_idx == 11'h002)
                        ? (s_axil_wdata[NUM_CLUSTERS-1:0] & w_wmask[NUM_CLUSTERS-1:0]) : '0;
    assign w_eoc_rise   = cl_eoc_i & ~r_eoc_prev;

    always_comb begin
        w_mpq_pad = '0;
        w_mpq_pad[NUM_MPQ-1:0] = mpq_full_i;
        w_valid32 = '0;
        for (int c = 0; c < NUM_VALID_BITS; c++) begin
            w_valid32[c] = stdout_data_valid[c];
        end
    end

    // Read mux: unmapped offsets fall through to the all-ones SLVERR default.
    always_comb begin
        w_rd_data = 32'hFFFF_FFFF;
        w_rd_resp = RESP_SLVERR;
        w_pop     = '0;
        if (w_rd_idx == 11'h000) begin
            w_rd_data = 32'(r_fetch_en);
            w_rd_resp = RESP_OKAY;
        end
        if (w_rd_idx == 11'h001) begin
            w_rd_data = {31'd0, r_aux_rst};
            w_rd_resp = RESP_OKAY;
        end
        if (w_rd_idx == 11'h002) begin
            w_rd_data = 32'(r_eoc_sticky);
            w_rd_resp = RESP_OKAY;
        end
        if (w_rd_idx == 11'h040) begin
            w_rd_data = 32'(cl_eoc_i);
            w_rd_resp = RESP_OKAY;
        end
        if (w_rd_idx == 11'h041) begin
            w_rd_data = 32'(cl_busy_i);
            w_rd_resp = RESP_OKAY;
        end
        for (int k = 0; k < NUM_MPQ_WORDS; k++) begin
            if (w_rd_idx == 11'(32'h042 + k)) begin
                w_rd_data = w_mpq_pad[32*k +: 32];
                w_rd_resp = RESP_OKAY;
            end
        end
        // An empty channel still answers OKAY, with the all-ones default as data.
        for (int c = 0; c < NUM_STDOUT; c++) begin
            if (w_rd_idx == 11'(32'h400 + c)) begin
                w_rd_resp = RESP_OKAY;
                if (stdout_data_valid[c]) begin
                    w_rd_data = stdout_dout[32*c +: 32];
                    w_pop[c]  = 1'b1;
                end
            end
        end
        if (w_rd_idx == 11'h600) begin
            w_rd_data = w_valid32;
            w_rd_resp = RESP_OKAY;
        end
    end

    assign stdout_rd_en = (w_rd_hs && !rst) ? w_pop : '0;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awready    <= 1'b0;
            r_arready    <= 1'b0;
            r_bvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_rresp      <= RESP_OKAY;
            r_rdata      <= '0;
            r_fetch_en   <= '0;
            r_aux_rst    <= 1'b1;
            r_eoc_sticky <= '0;
            r_eoc_prev   <= '0;
        end else begin
            r_awready    <= s_axil_awvalid && s_axil_wvalid && !r_bvalid && !r_awready;
            r_arready    <= s_axil_arvalid && !r_rvalid && !r_arready;
            r_eoc_prev   <= cl_eoc_i;
            r_eoc_sticky <= (r_eoc_sticky & ~w_eoc_clr) | w_eoc_rise;

            if (w_wr_hs) begin
                if (w_wr_idx == 11'h000) r_fetch_en <= w_fetch_next;
                if (w_wr_idx == 11'h001 && s_axil_wstrb[0]) r_aux_rst <= s_axil_wdata[0];
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end

            if (w_rd_hs) begin
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
                r_rvalid <= 1'b1;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_awready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign cl_fetch_en_o  = r_fetch_en;
    assign aux_rst_o      = r_aux_rst;

endmodule

// File: tb/tb_pspin_ctrl_regfile.sv
// Directed bench for pspin_ctrl_regfile; expected responses are queued at issue
// and compared when the DUT answers.
module tb_pspin_ctrl_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [15:0] s_axil_araddr = '0;
    logic [2:0]  s_axil_arprot = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic [1:0]  cl_fetch_en_o;
    logic        aux_rst_o;
    logic [1:0]  cl_eoc_i = '0;
    logic [1:0]  cl_busy_i = '0;
    logic [255:0] mpq_full_i = '0;
    logic [1:0]  stdout_rd_en;
    logic [63:0] stdout_dout = '0;
    logic [1:0]  stdout_data_valid = '0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t       rd_q[$];
    logic [1:0] wr_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt0 = 0;
    int pop_cnt1 = 0;
    int aw_cnt   = 0;

    pspin_ctrl_regfile dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .cl_fetch_en_o(cl_fetch_en_o), .aux_rst_o(aux_rst_o),
        .cl_eoc_i(cl_eoc_i), .cl_busy_i(cl_busy_i), .mpq_full_i(mpq_full_i),
        .stdout_rd_en(stdout_rd_en), .stdout_dout(stdout_dout),
        .stdout_data_valid(stdout_data_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        pop_cnt0 += int'(stdout_rd_en[0]);
        pop_cnt1 += int'(stdout_rd_en[1]);
        aw_cnt   += int'(s_axil_awready);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input string tag, input bit eoc_on_hs);
        bit got = 0;
        wr_q.push_back(exp_resp);
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (s_axil_awready) begin
                got = 1;
                if (eoc_on_hs) cl_eoc_i[1] = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        if (eoc_on_hs) cl_eoc_i[1] = 1'b0;
        check({tag, " aw_accept"}, 32'(got), 32'd1);
        for (int i = 0; i < 50 && !s_axil_bvalid; i++) begin
            @(posedge clk); #1;
        end
        check({tag, " bvalid"}, 32'(s_axil_bvalid), 32'd1);
        if (wr_q.size() == 0) check({tag, " wr_q_empty"}, 32'd1, 32'd0);
        else check({tag, " bresp"}, 32'(s_axil_bresp), 32'(wr_q.pop_front()));
        s_axil_bready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input string tag, input int hold);
        bit   got = 0;
        exp_t e;
        rd_q.push_back('{tag, exp_data, exp_resp});
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (s_axil_arready) got = 1;
            @(posedge clk); #1;
        end
        s_axil_arvalid = 1'b0;
        check({tag, " ar_accept"}, 32'(got), 32'd1);
        for (int i = 0; i < 50 && !s_axil_rvalid; i++) begin
            @(posedge clk); #1;
        end
        check({tag, " rvalid"}, 32'(s_axil_rvalid), 32'd1);
        if (rd_q.size() == 0) begin
            check({tag, " rd_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = rd_q.pop_front();
            check({e.tag, " rdata"}, s_axil_rdata, e.data);
            check({e.tag, " rresp"}, 32'(s_axil_rresp), 32'(e.resp));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check({e.tag, " held rvalid"}, 32'(s_axil_rvalid), 32'd1);
                check({e.tag, " held rdata"}, s_axil_rdata, e.data);
            end
        end
        s_axil_rready = 1'b1;
        @(posedge clk); #1;
        s_axil_rready = 1'b0;
    endtask

    initial begin
        int aw_base;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst aux_rst_o", 32'(aux_rst_o), 32'd1);
        check("rst fetch_en", 32'(cl_fetch_en_o), 32'd0);
        check("rst bvalid", 32'(s_axil_bvalid), 32'd0);
        check("rst rvalid", 32'(s_axil_rvalid), 32'd0);
        check("rst awready", 32'(s_axil_awready), 32'd0);
        do_read(16'h0004, 32'h1, 2'b00, "rd aux reset", 0);
        do_read(16'h0000, 32'h0, 2'b00, "rd fetch reset", 0);
        do_read(16'h0008, 32'h0, 2'b00, "rd sticky reset", 0);

        do_write(16'h0000, 32'hFFFF_FFFF, 4'h1, 2'b00, "wr fetch all", 0);
        check("fetch_en 11", 32'(cl_fetch_en_o), 32'd3);
        do_read(16'h0000, 32'h3, 2'b00, "rd fetch 3", 0);
        do_write(16'h0000, 32'h0, 4'hE, 2'b00, "wr fetch upper lanes", 0);
        do_read(16'h0000, 32'h3, 2'b00, "rd fetch strobe kept", 0);
        do_write(16'h0004, 32'h0, 4'h1, 2'b00, "wr aux 0", 0);
        check("aux_rst_o 0", 32'(aux_rst_o), 32'd0);
        do_read(16'h0004, 32'h0, 2'b00, "rd aux 0", 0);
        do_write(16'h0100, 32'h1, 4'hF, 2'b10, "wr ro eoc", 0);
        do_write(16'h0200, 32'h1, 4'hF, 2'b10, "wr unmapped", 0);

        fork
            do_write(16'h0000, 32'h1, 4'hF, 2'b00, "wr fetch concurrent", 0);
            do_read(16'h0000, 32'h3, 2'b00, "rd fetch pre-write", 0);
        join
        check("fetch_en 01", 32'(cl_fetch_en_o), 32'd1);
        do_read(16'h0000, 32'h1, 2'b00, "rd fetch post-write", 0);

        cl_eoc_i = 2'b10;
        @(posedge clk); #1;
        cl_eoc_i = 2'b00;
        do_read(16'h0008, 32'h2, 2'b00, "rd sticky set", 0);
        do_read(16'h0100, 32'h0, 2'b00, "rd eoc live 0", 0);
        do_write(16'h0008, 32'h1, 4'hF, 2'b00, "w1c other bit", 0);
        do_read(16'h0008, 32'h2, 2'b00, "rd sticky w0 keeps", 0);
        do_write(16'h0008, 32'h2, 4'hF, 2'b00, "w1c with rise", 1);
        do_read(16'h0008, 32'h2, 2'b00, "rd sticky set wins", 0);
        do_write(16'h0008, 32'h2, 4'hF, 2'b00, "w1c clear", 0);
        do_read(16'h0008, 32'h0, 2'b00, "rd sticky cleared", 0);

        cl_eoc_i  = 2'b01;
        cl_busy_i = 2'b10;
        do_read(16'h0100, 32'h1, 2'b00, "rd eoc live", 0);
        do_read(16'h0104, 32'h2, 2'b00, "rd busy live", 0);
        cl_eoc_i = 2'b00;
        do_read(16'h0008, 32'h1, 2'b00, "rd sticky bit0", 0);

        mpq_full_i[40]  = 1'b1;
        mpq_full_i[255] = 1'b1;
        do_read(16'h010C, 32'h0000_0100, 2'b00, "rd mpq word1", 0);
        do_read(16'h0108, 32'h0, 2'b00, "rd mpq word0", 0);
        do_read(16'h0124, 32'h8000_0000, 2'b00, "rd mpq word7", 0);
        do_read(16'h0128, 32'hFFFF_FFFF, 2'b10, "rd mpq beyond", 0);

        stdout_dout       = {32'hDEAD_BEEF, 32'h1234_5678};
        stdout_data_valid = 2'b11;
        do_read(16'h1004, 32'hDEAD_BEEF, 2'b00, "pop ch1 stalled", 5);
        check("pop ch1 count", 32'(pop_cnt1), 32'd1);
        check("pop ch0 untouched", 32'(pop_cnt0), 32'd0);
        do_read(16'h1800, 32'h3, 2'b00, "rd stdout valid 3", 0);
        stdout_data_valid = 2'b01;
        do_read(16'h1004, 32'hFFFF_FFFF, 2'b00, "pop ch1 empty", 0);
        check("pop ch1 no extra", 32'(pop_cnt1), 32'd1);
        do_read(16'h1000, 32'h1234_5678, 2'b00, "pop ch0", 0);
        check("pop ch0 count", 32'(pop_cnt0), 32'd1);
        do_read(16'h1008, 32'hFFFF_FFFF, 2'b10, "pop ch2 unmapped", 0);
        do_read(16'h1800, 32'h1, 2'b00, "rd stdout valid 1", 0);

        s_axil_awaddr  = 16'h0000;
        s_axil_awvalid = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            seen |= s_axil_awready;
        end
        check("lone aw not accepted", 32'(seen), 32'd0);
        aw_base = aw_cnt;
        do_write(16'h0000, 32'h2, 4'hF, 2'b00, "wr after lone aw", 0);
        check("single aw accept", 32'(aw_cnt - aw_base), 32'd1);
        check("fetch_en 10", 32'(cl_fetch_en_o), 32'd2);

        s_axil_awaddr  = 16'h0000;
        s_axil_wdata   = 32'h3;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        for (int i = 0; i < 50 && !s_axil_bvalid; i++) begin
            @(posedge clk); #1;
            if (s_axil_awready) begin
                @(posedge clk); #1;
                s_axil_awvalid = 1'b0;
                s_axil_wvalid  = 1'b0;
            end
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("bvalid pending", 32'(s_axil_bvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst drops bvalid", 32'(s_axil_bvalid), 32'd0);
        check("rst fetch_en again", 32'(cl_fetch_en_o), 32'd0);
        check("rst aux again", 32'(aux_rst_o), 32'd1);
        do_read(16'h0004, 32'h1, 2'b00, "rd aux after rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
